// File: rtl/store_data_formatter.sv
// Store data formatter: places sb/sh/sw data into little-endian byte lanes,
// drives one Avalon-MM write and holds it stable across waitrequest. It then
// reports done, misaligned or timeout for one cycle before going idle again.
module store_data_formatter #(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        store_valid,
  input  logic [1:0]  store_type,
  input  logic [31:0] store_addr,
  input  logic [31:0] rt_data,
  output logic        store_ready,
  output logic        store_done,
  output logic        store_misaligned,
  output logic        store_timeout,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest
);

  typedef enum logic [1:0] {ST_NONE = 2'b00, ST_SB = 2'b01, ST_SH = 2'b10, ST_SW = 2'b11} store_kind_e;
  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_e;

  state_e           state;
  logic [CNT_W-1:0] wait_cnt;

  // Byte enables for the addressed lanes; a byte store selects a single lane.
  function automatic logic [3:0] lane_be(input logic [1:0] kind, input logic [1:0] a);
    // NOTE: every path assigns a value first, so the function never implies a latch.
    lane_be = 4'b0000;
    case (kind)
      ST_SB:   lane_be = 4'b0001 << a;
      ST_SH:   lane_be = a[1] ? 4'b1100 : 4'b0011;
      ST_SW:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  // Store data shifted into its lanes; unused lanes are driven to zero.
  function automatic logic [31:0] lane_data(input logic [1:0] kind, input logic [1:0] a,
                                            input logic [31:0] d);
    lane_data = 32'h0;
    case (kind)
      ST_SB:   lane_data = 32'(d[7:0]) << {a, 3'b000};
      ST_SH:   lane_data = a[1] ? {d[15:0], 16'h0} : {16'h0, d[15:0]};
      ST_SW:   lane_data = d;
      default: lane_data = 32'h0;
    endcase
  endfunction

  logic req_accept;
  logic req_misaligned;

  // Request decode: sb never misaligned, sh needs addr[0]=0, sw needs addr[1:0]=0.
  always_comb begin
    req_accept     = store_valid && (store_type != ST_NONE);
    req_misaligned = ((store_type == ST_SH) && store_addr[0]) ||
                     ((store_type == ST_SW) && (store_addr[1:0] != 2'b00));
  end

  // Control FSM with all outputs registered; reset drops the bus write at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: only a handful of flops here, so every register gets a reset value.
    if (reset) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      store_ready      <= 1'b1;
      store_done       <= 1'b0;
      store_misaligned <= 1'b0;
      store_timeout    <= 1'b0;
      avm_address      <= 32'h0;
      avm_write        <= 1'b0;
      avm_writedata    <= 32'h0;
      avm_byteenable   <= 4'b0000;
    end else begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      case (state)
        IDLE: begin
          if (req_accept) begin
            store_ready <= 1'b0;
            if (req_misaligned) begin
              store_misaligned <= 1'b1;
              state            <= RESP;
            end else begin
              avm_address    <= {store_addr[31:2], 2'b00};
              avm_writedata  <= lane_data(store_type, store_addr[1:0], rt_data);
              avm_byteenable <= lane_be(store_type, store_addr[1:0]);
              avm_write      <= 1'b1;
              state          <= WRITE;
            end
          end
        end
        WRITE: begin
          if (!avm_waitrequest) begin
            // Completion wins over a timeout on the same edge.
            avm_write      <= 1'b0;
            avm_byteenable <= 4'b0000;
            store_done     <= 1'b1;
            state          <= RESP;
          end else if ((WAIT_TIMEOUT != 0) && (wait_cnt == CNT_W'(WAIT_TIMEOUT))) begin
            avm_write      <= 1'b0;
            avm_byteenable <= 4'b0000;
            store_timeout  <= 1'b1;
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          store_done       <= 1'b0;
          store_misaligned <= 1'b0;
          store_timeout    <= 1'b0;
          wait_cnt         <= '0;
          store_ready      <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_data_formatter.sv
// Directed bench for store_data_formatter with WAIT_TIMEOUT=4. Inputs change
// and outputs are sampled on the falling clock edge.
module tb_store_data_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic        store_valid;
  logic [1:0]  store_type;
  logic [31:0] store_addr;
  logic [31:0] rt_data;
  logic        store_ready, store_done, store_misaligned, store_timeout;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;

  int total = 0;
  int bad   = 0;

  store_data_formatter #(.WAIT_TIMEOUT(4), .CNT_W(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .store_valid      (store_valid),
    .store_type       (store_type),
    .store_addr       (store_addr),
    .rt_data          (rt_data),
    .store_ready      (store_ready),
    .store_done       (store_done),
    .store_misaligned (store_misaligned),
    .store_timeout    (store_timeout),
    .avm_address      (avm_address),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_waitrequest  (avm_waitrequest)
  );

  always #5 clk = ~clk;

  // Present a request for one rising edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    store_valid = 1'b1;
    store_type  = t;
    store_addr  = a;
    rt_data     = d;
    @(negedge clk);
    store_valid = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (store_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b exp 1", store_ready); end
    total++; if ({avm_write, store_done, store_misaligned, store_timeout} !== 4'b0000) begin
      bad++; $display("FAIL reset_pulses got %b exp 0000", {avm_write, store_done, store_misaligned, store_timeout}); end
    total++; if ({avm_address, avm_writedata, avm_byteenable} !== 68'h0) begin
      bad++; $display("FAIL reset_bus got %h/%h/%b exp 0", avm_address, avm_writedata, avm_byteenable); end
  endtask

  task automatic test_type_none;
    issue(2'b00, 32'h0000_5000, 32'h1111_1111);
    total++; if ({store_ready, avm_write} !== 2'b10) begin
      bad++; $display("FAIL none_ignored got ready/write %b exp 10", {store_ready, avm_write}); end
  endtask

  task automatic test_sw;
    avm_waitrequest = 1'b0;
    issue(2'b11, 32'h0000_1004, 32'hDEAD_BEEF);
    total++; if ({avm_write, store_ready} !== 2'b10) begin
      bad++; $display("FAIL sw_write got write/ready %b exp 10", {avm_write, store_ready}); end
    total++; if (avm_address !== 32'h0000_1004) begin bad++; $display("FAIL sw_addr got %h exp 00001004", avm_address); end
    total++; if (avm_writedata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_data got %h exp deadbeef", avm_writedata); end
    total++; if (avm_byteenable !== 4'b1111) begin bad++; $display("FAIL sw_be got %b exp 1111", avm_byteenable); end
    @(negedge clk);
    total++; if ({store_done, avm_write, avm_byteenable, store_ready} !== 7'b1_0_0000_0) begin
      bad++; $display("FAIL sw_done got done/write/be/ready %b exp 1000000", {store_done, avm_write, avm_byteenable, store_ready}); end
    @(negedge clk);
    total++; if ({store_ready, store_done} !== 2'b10) begin
      bad++; $display("FAIL sw_ready got ready/done %b exp 10", {store_ready, store_done}); end
  endtask

  task automatic test_sb;
    logic [31:0] addrs [2] = '{32'h0000_2003, 32'h0000_2001};
    logic [31:0] datas [2] = '{32'hA500_0000, 32'h0000_A500};
    logic [3:0]  bes   [2] = '{4'b1000, 4'b0010};
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 2; i++) begin
      issue(2'b01, addrs[i], 32'h1234_56A5);
      total++; if ({avm_write, avm_address} !== {1'b1, 32'h0000_2000}) begin
        bad++; $display("FAIL sb_addr[%0d] got write=%b addr=%h exp 1/00002000", i, avm_write, avm_address); end
      total++; if ({avm_writedata, avm_byteenable} !== {datas[i], bes[i]}) begin
        bad++; $display("FAIL sb_lane[%0d] got %h/%b exp %h/%b", i, avm_writedata, avm_byteenable, datas[i], bes[i]); end
      @(negedge clk);
      total++; if (store_done !== 1'b1) begin bad++; $display("FAIL sb_done[%0d] got %b exp 1", i, store_done); end
      @(negedge clk);
    end
  endtask

  task automatic test_sh_wait;
    avm_waitrequest = 1'b1;
    issue(2'b10, 32'h0000_3002, 32'hFFFF_8001);
    // Inputs wiggle during the write; the latched bus values must not move.
    store_addr = 32'h0000_7777;
    rt_data    = 32'h5555_5555;
    store_type = 2'b11;
    for (int i = 0; i < 4; i++) begin
      total++; if ({avm_write, avm_address, avm_writedata, avm_byteenable, store_done} !==
                   {1'b1, 32'h0000_3000, 32'h8001_0000, 4'b1100, 1'b0}) begin
        bad++; $display("FAIL sh_hold[%0d] got w=%b a=%h d=%h be=%b done=%b exp 1/00003000/80010000/1100/0",
                        i, avm_write, avm_address, avm_writedata, avm_byteenable, store_done); end
      if (i == 3) avm_waitrequest = 1'b0;
      @(negedge clk);
    end
    total++; if ({store_done, avm_write, store_timeout} !== 3'b100) begin
      bad++; $display("FAIL sh_done got done/write/timeout %b exp 100", {store_done, avm_write, store_timeout}); end
    @(negedge clk);
    total++; if (store_ready !== 1'b1) begin bad++; $display("FAIL sh_ready got %b exp 1", store_ready); end
  endtask

  task automatic test_misaligned;
    logic [1:0]  types [2] = '{2'b10, 2'b11};
    logic [31:0] addrs [2] = '{32'h0000_3001, 32'h0000_3006};
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 2; i++) begin
      issue(types[i], addrs[i], 32'hCAFE_F00D);
      total++; if ({store_misaligned, avm_write, store_ready, store_done} !== 4'b1000) begin
        bad++; $display("FAIL mis_pulse[%0d] got mis/write/ready/done %b exp 1000", i,
                        {store_misaligned, avm_write, store_ready, store_done}); end
      @(negedge clk);
      total++; if ({store_ready, store_misaligned, avm_write} !== 3'b100) begin
        bad++; $display("FAIL mis_ready[%0d] got ready/mis/write %b exp 100", i, {store_ready, store_misaligned, avm_write}); end
    end
  endtask

  task automatic test_timeout;
    // Stuck waitrequest: five write cycles, then a timeout pulse.
    avm_waitrequest = 1'b1;
    issue(2'b11, 32'h0000_4000, 32'h0BAD_0BAD);
    for (int i = 0; i < 5; i++) begin
      total++; if ({avm_write, store_timeout} !== 2'b10) begin
        bad++; $display("FAIL to_write[%0d] got write/timeout %b exp 10", i, {avm_write, store_timeout}); end
      @(negedge clk);
    end
    total++; if ({store_timeout, store_done, avm_write, avm_byteenable} !== 7'b1000000) begin
      bad++; $display("FAIL to_pulse got to/done/write/be %b exp 1000000", {store_timeout, store_done, avm_write, avm_byteenable}); end
    @(negedge clk);
    total++; if ({store_ready, store_timeout} !== 2'b10) begin
      bad++; $display("FAIL to_idle got ready/timeout %b exp 10", {store_ready, store_timeout}); end
    // Waitrequest falls exactly on the would-be timeout edge: done wins.
    issue(2'b11, 32'h0000_4004, 32'h0BAD_0BAD);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) avm_waitrequest = 1'b0;
      @(negedge clk);
    end
    total++; if ({store_done, store_timeout} !== 2'b10) begin
      bad++; $display("FAIL to_priority got done/timeout %b exp 10", {store_done, store_timeout}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    avm_waitrequest = 1'b1;
    issue(2'b11, 32'h0000_6000, 32'h1357_9BDF);
    @(negedge clk);
    @(negedge clk);
    total++; if (avm_write !== 1'b1) begin bad++; $display("FAIL rst_pre got write %b exp 1", avm_write); end
    #1 reset = 1'b1;
    #1;
    total++; if ({avm_write, avm_byteenable, store_done, store_misaligned, store_timeout, store_ready} !== 9'b0_0000_000_1) begin
      bad++; $display("FAIL rst_async got w/be/d/m/t/r %b exp 000000001",
                      {avm_write, avm_byteenable, store_done, store_misaligned, store_timeout, store_ready}); end
    @(negedge clk);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    total++; if ({store_ready, store_done, store_timeout, avm_write} !== 4'b1000) begin
      bad++; $display("FAIL rst_after got ready/done/to/write %b exp 1000", {store_ready, store_done, store_timeout, avm_write}); end
    issue(2'b11, 32'h0000_6008, 32'h2468_ACE0);
    total++; if ({avm_write, avm_address, avm_writedata} !== {1'b1, 32'h0000_6008, 32'h2468_ACE0}) begin
      bad++; $display("FAIL rst_next_write got %b/%h/%h exp 1/00006008/2468ace0", avm_write, avm_address, avm_writedata); end
    @(negedge clk);
    total++; if (store_done !== 1'b1) begin bad++; $display("FAIL rst_next_done got %b exp 1", store_done); end
    @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    store_valid     = 1'b0;
    store_type      = 2'b00;
    store_addr      = 32'h0;
    rt_data         = 32'h0;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    test_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_type_none;
    test_sw;
    test_sb;
    test_sh_wait;
    test_misaligned;
    test_timeout;
    test_reset_mid_write;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
